// File: rtl/axis_video_frame_monitor.sv
// Passive AXI4-Stream video frame monitor.
// Measures line width and frame height, checks them against programmed values, and counts
// completed and errored frames. Never drives tready.
// Optional build macro VID_MON_CHECKSUM_EN adds a per-frame rotate-XOR checksum; without it
// frame_checksum is tied to zero.
module axis_video_frame_monitor #(
    parameter int unsigned PPC   = 2,
    parameter int unsigned BPP   = 24,
    parameter int unsigned DIM_W = 16,
    parameter int unsigned CNT_W = 32
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 enable,
    input  logic                 clr_err,
    input  logic [DIM_W-1:0]     exp_width,
    input  logic [DIM_W-1:0]     exp_height,
    input  logic [PPC*BPP-1:0]   s_axis_tdata,
    input  logic                 s_axis_tvalid,
    input  logic                 s_axis_tready,
    input  logic                 s_axis_tuser,
    input  logic                 s_axis_tlast,
    output logic [DIM_W-1:0]     meas_width,
    output logic [DIM_W-1:0]     meas_height,
    output logic                 frame_done,
    output logic                 frame_ok,
    output logic [CNT_W-1:0]     frame_count,
    output logic [15:0]          err_count,
    output logic                 err_line_len,
    output logic                 err_frame_len,
    output logic                 err_sof_midline,
    output logic [31:0]          frame_checksum
);

    localparam int unsigned     DataW    = PPC * BPP;
    localparam int unsigned     PpcShift = $clog2(PPC);
    localparam logic [DIM_W-1:0] DimMax  = '1;

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    state_e           state_q, state_d;
    logic [DIM_W-1:0] line_beats_q, line_beats_d;
    logic [DIM_W-1:0] line_cnt_q, line_cnt_d;
    logic             bad_q, bad_d;
    logic [DIM_W-1:0] meas_width_q, meas_width_d;
    logic [DIM_W-1:0] meas_height_q, meas_height_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_ok_q, frame_ok_d;
    logic [CNT_W-1:0] frame_count_q, frame_count_d;
    logic [15:0]      err_count_q, err_count_d;
    logic             err_line_len_q, err_line_len_d;
    logic             err_frame_len_q, err_frame_len_d;
    logic             err_sof_midline_q, err_sof_midline_d;

    logic             beat;
    logic             proc_beat;
    logic             close_frame;
    logic [DIM_W-1:0] lb, lc, beats_inc, line_width;
    logic             bd, close_bad;

    // A beat is only processed while enabled, and in IDLE only the arming SOF counts.
    assign beat        = s_axis_tvalid & s_axis_tready;
    assign proc_beat   = enable & beat & ((state_q == StActive) | s_axis_tuser);
    assign close_frame = proc_beat & s_axis_tuser & (state_q == StActive);

    // Next-state: line/frame counting, frame closing and sticky error bookkeeping.
    always_comb begin
        state_d           = state_q;
        line_beats_d      = line_beats_q;
        line_cnt_d        = line_cnt_q;
        bad_d             = bad_q;
        meas_width_d      = meas_width_q;
        meas_height_d     = meas_height_q;
        frame_done_d      = 1'b0;
        frame_ok_d        = frame_ok_q;
        frame_count_d     = frame_count_q;
        // Clear first so an error raised in the same cycle still lands.
        err_count_d       = clr_err ? 16'h0 : err_count_q;
        err_line_len_d    = err_line_len_q & ~clr_err;
        err_frame_len_d   = err_frame_len_q & ~clr_err;
        err_sof_midline_d = err_sof_midline_q & ~clr_err;
        lb                = line_beats_q;
        lc                = line_cnt_q;
        bd                = bad_q;
        beats_inc         = '0;
        line_width        = '0;
        close_bad         = 1'b0;

        if (!enable) begin
            state_d      = StIdle;
            line_beats_d = '0;
            line_cnt_d   = '0;
            bad_d        = 1'b0;
        end else if (proc_beat) begin
            state_d = StActive;
            if (s_axis_tuser) begin
                if (close_frame) begin
                    close_bad = bad_q;
                    if (line_beats_q != '0) begin
                        err_sof_midline_d = 1'b1;
                        close_bad         = 1'b1;
                    end
                    if (line_cnt_q != exp_height || line_cnt_q == DimMax) begin
                        err_frame_len_d = 1'b1;
                        close_bad       = 1'b1;
                    end
                    frame_done_d  = 1'b1;
                    frame_ok_d    = ~close_bad;
                    meas_height_d = line_cnt_q;
                    frame_count_d = frame_count_q + 1'b1;
                    if (close_bad && err_count_d != 16'hFFFF) begin
                        err_count_d = err_count_d + 1'b1;
                    end
                end
                // The SOF beat opens line 0 of the new frame.
                lb = '0;
                lc = '0;
                bd = 1'b0;
            end
            if (s_axis_tlast) begin
                beats_inc    = (lb == DimMax) ? lb : lb + 1'b1;
                line_width   = beats_inc << PpcShift;
                meas_width_d = line_width;
                if (line_width != exp_width || lb == DimMax) begin
                    err_line_len_d = 1'b1;
                    bd             = 1'b1;
                end
                lb = '0;
                lc = (lc == DimMax) ? lc : lc + 1'b1;
            end else begin
                lb = (lb == DimMax) ? lb : lb + 1'b1;
            end
            line_beats_d = lb;
            line_cnt_d   = lc;
            bad_d        = bd;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q           <= StIdle;
            line_beats_q      <= '0;
            line_cnt_q        <= '0;
            bad_q             <= 1'b0;
            meas_width_q      <= '0;
            meas_height_q     <= '0;
            frame_done_q      <= 1'b0;
            frame_ok_q        <= 1'b0;
            frame_count_q     <= '0;
            err_count_q       <= '0;
            err_line_len_q    <= 1'b0;
            err_frame_len_q   <= 1'b0;
            err_sof_midline_q <= 1'b0;
        end else begin
            state_q           <= state_d;
            line_beats_q      <= line_beats_d;
            line_cnt_q        <= line_cnt_d;
            bad_q             <= bad_d;
            meas_width_q      <= meas_width_d;
            meas_height_q     <= meas_height_d;
            frame_done_q      <= frame_done_d;
            frame_ok_q        <= frame_ok_d;
            frame_count_q     <= frame_count_d;
            err_count_q       <= err_count_d;
            err_line_len_q    <= err_line_len_d;
            err_frame_len_q   <= err_frame_len_d;
            err_sof_midline_q <= err_sof_midline_d;
        end
    end

`ifdef VID_MON_CHECKSUM_EN
    localparam int unsigned NSlices = (DataW + 31) / 32;

    logic [NSlices*32-1:0] data_pad;
    logic [31:0]           fold, acc_base;
    logic [31:0]           acc_q, acc_d;
    logic [31:0]           checksum_q, checksum_d;

    assign data_pad = (NSlices * 32)'(s_axis_tdata);

    // Fold the beat into 32 bits and run the rotate-XOR accumulator.
    always_comb begin
        fold       = '0;
        acc_base   = acc_q;
        acc_d      = acc_q;
        checksum_d = checksum_q;
        for (int i = 0; i < int'(NSlices); i++) begin
            fold = fold ^ data_pad[i*32 +: 32];
        end
        if (proc_beat) begin
            if (close_frame) begin
                checksum_d = acc_q;
            end
            if (s_axis_tuser) begin
                acc_base = '0;
            end
            acc_d = {acc_base[30:0], acc_base[31]} ^ fold;
        end
    end

    // Checksum registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            acc_q      <= '0;
            checksum_q <= '0;
        end else begin
            acc_q      <= acc_d;
            checksum_q <= checksum_d;
        end
    end

    assign frame_checksum = checksum_q;
`else
    assign frame_checksum = 32'h0;
`endif

    assign meas_width      = meas_width_q;
    assign meas_height     = meas_height_q;
    assign frame_done      = frame_done_q;
    assign frame_ok        = frame_ok_q;
    assign frame_count     = frame_count_q;
    assign err_count       = err_count_q;
    assign err_line_len    = err_line_len_q;
    assign err_frame_len   = err_frame_len_q;
    assign err_sof_midline = err_sof_midline_q;

endmodule

// File: tb/tb_axis_video_frame_monitor.sv
// Directed bench for axis_video_frame_monitor: PPC=2, small 8x3 frames (4 beats per line).
module tb_axis_video_frame_monitor;

    localparam int unsigned PPC   = 2;
    localparam int unsigned BPP   = 24;
    localparam int unsigned DIM_W = 16;
    localparam int unsigned CNT_W = 32;

    logic               aclk;
    logic               aresetn;
    logic               enable;
    logic               clr_err;
    logic [DIM_W-1:0]   exp_width;
    logic [DIM_W-1:0]   exp_height;
    logic [PPC*BPP-1:0] s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic               s_axis_tuser;
    logic               s_axis_tlast;
    logic [DIM_W-1:0]   meas_width;
    logic [DIM_W-1:0]   meas_height;
    logic               frame_done;
    logic               frame_ok;
    logic [CNT_W-1:0]   frame_count;
    logic [15:0]        err_count;
    logic               err_line_len;
    logic               err_frame_len;
    logic               err_sof_midline;
    logic [31:0]        frame_checksum;

    int                 vec_cnt  = 0;
    int                 miss_cnt = 0;
    int                 done_seen = 0;
    logic [47:0]        dval = '0;

    axis_video_frame_monitor #(
        .PPC   (PPC),
        .BPP   (BPP),
        .DIM_W (DIM_W),
        .CNT_W (CNT_W)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .enable          (enable),
        .clr_err         (clr_err),
        .exp_width       (exp_width),
        .exp_height      (exp_height),
        .s_axis_tdata    (s_axis_tdata),
        .s_axis_tvalid   (s_axis_tvalid),
        .s_axis_tready   (s_axis_tready),
        .s_axis_tuser    (s_axis_tuser),
        .s_axis_tlast    (s_axis_tlast),
        .meas_width      (meas_width),
        .meas_height     (meas_height),
        .frame_done      (frame_done),
        .frame_ok        (frame_ok),
        .frame_count     (frame_count),
        .err_count       (err_count),
        .err_line_len    (err_line_len),
        .err_frame_len   (err_frame_len),
        .err_sof_midline (err_sof_midline),
        .frame_checksum  (frame_checksum)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // Count frame_done pulses mid-cycle, away from the active edge.
    always @(negedge aclk) begin
        if (frame_done === 1'b1) done_seen++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        assert (obs === exp) else begin
            miss_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the edge that consumed them.
    task automatic step(input logic v, input logic r, input logic u, input logic l);
        s_axis_tvalid = v;
        s_axis_tready = r;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        s_axis_tdata  = dval;
        dval          = dval + 48'd1;
        @(posedge aclk);
        #1;
    endtask

    // One line; with stall, non-beats carrying tuser/tlast are interleaved and must be ignored.
    task automatic send_line(input int beats, input bit sof, input bit stall);
        for (int i = 0; i < beats; i++) begin
            if (stall && (i % 2 == 0)) step(1'b1, 1'b0, 1'b1, 1'b1);
            if (stall && i == 1) step(1'b0, 1'b1, 1'b1, 1'b1);
            step(1'b1, 1'b1, sof && i == 0, i == beats - 1);
        end
    endtask

    task automatic send_frame(input int lines, input int beats, input int short_ln,
                              input bit stall);
        for (int l = 0; l < lines; l++) begin
            send_line((l == short_ln) ? beats - 1 : beats, l == 0, stall);
        end
    endtask

    initial begin
        aresetn = 1'b0;
        enable = 1'b0;
        clr_err = 1'b0;
        exp_width = 16'd8;
        exp_height = 16'd3;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tready = 1'b0;
        s_axis_tuser = 1'b0;
        s_axis_tlast = 1'b0;
        repeat (3) step(1'b1, 1'b1, 1'b1, 1'b1);
        aresetn = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_meas_width", 64'(meas_width), 64'd0);
        chk("rst_meas_height", 64'(meas_height), 64'd0);
        chk("rst_frame_done", 64'(frame_done), 64'd0);
        chk("rst_frame_ok", 64'(frame_ok), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_err_flags", 64'({err_line_len, err_frame_len, err_sof_midline}), 64'd0);
        chk("rst_checksum", 64'(frame_checksum), 64'd0);

        // Clean frames A, B, C; A arms from IDLE without a frame_done.
        enable = 1'b1;
        send_frame(3, 4, -1, 1'b0);
        chk("a_no_done", 64'(done_seen), 64'd0);
        chk("a_meas_width", 64'(meas_width), 64'd8);
        chk("a_frame_count", 64'(frame_count), 64'd0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("b_sof_done", 64'(frame_done), 64'd1);
        chk("b_sof_ok", 64'(frame_ok), 64'd1);
        chk("b_sof_height", 64'(meas_height), 64'd3);
        chk("b_sof_count", 64'(frame_count), 64'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("b_done_pulse", 64'(frame_done), 64'd0);
        send_line(3, 1'b0, 1'b0);
        send_line(4, 1'b0, 1'b0);
        send_line(4, 1'b0, 1'b0);
        send_frame(3, 4, -1, 1'b0);
        chk("c_done_seen", 64'(done_seen), 64'd2);
        chk("c_frame_count", 64'(frame_count), 64'd2);
        chk("c_err_count", 64'(err_count), 64'd0);
        chk("c_meas", 64'({meas_width, meas_height}), {32'd0, 16'd8, 16'd3});

        // D with backpressure, then E with a 6-pixel line 1.
        send_frame(3, 4, -1, 1'b1);
        chk("d_done_seen", 64'(done_seen), 64'd3);
        chk("d_meas_width", 64'(meas_width), 64'd8);
        send_frame(3, 4, 1, 1'b0);
        chk("e_d_ok", 64'(frame_ok), 64'd1);
        chk("e_d_height", 64'(meas_height), 64'd3);
        chk("e_count", 64'(frame_count), 64'd4);
        chk("e_err_line_len", 64'(err_line_len), 64'd1);
        chk("e_err_count", 64'(err_count), 64'd0);
        send_frame(3, 4, -1, 1'b0);
        chk("f_e_ok", 64'(frame_ok), 64'd0);
        chk("f_err_count", 64'(err_count), 64'd1);
        chk("f_count", 64'(frame_count), 64'd5);
        chk("f_other_flags", 64'({err_frame_len, err_sof_midline}), 64'd0);

        // G: two full lines plus two beats, then SOF mid-line.
        send_line(4, 1'b1, 1'b0);
        chk("g_f_ok", 64'(frame_ok), 64'd1);
        send_line(4, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("h_sof_done", 64'(frame_done), 64'd1);
        chk("h_midline", 64'(err_sof_midline), 64'd1);
        chk("h_frame_len", 64'(err_frame_len), 64'd1);
        chk("h_height", 64'(meas_height), 64'd2);
        chk("h_g_ok", 64'(frame_ok), 64'd0);
        chk("h_err_count", 64'(err_count), 64'd2);
        chk("h_count", 64'(frame_count), 64'd7);
        send_line(3, 1'b0, 1'b0);
        send_line(4, 1'b0, 1'b0);
        send_line(4, 1'b0, 1'b0);

        // I starts, then enable drops for 10 cycles with traffic present.
        send_line(4, 1'b1, 1'b0);
        chk("i_h_ok", 64'(frame_ok), 64'd1);
        chk("i_count", 64'(frame_count), 64'd8);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, i[0], i[1]);
        chk("dis_done_seen", 64'(done_seen), 64'd8);
        chk("dis_count", 64'(frame_count), 64'd8);
        chk("dis_err_kept", 64'(err_count), 64'd2);
        chk("dis_midline_kept", 64'(err_sof_midline), 64'd1);
        enable = 1'b1;
        send_frame(3, 4, -1, 1'b0);
        chk("j_rearm_no_done", 64'(done_seen), 64'd8);
        chk("j_count", 64'(frame_count), 64'd8);

        // K opens with SOF+EOL (2-pixel line); L closes K while clr_err is pulsed.
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("k_done", 64'(frame_done), 64'd1);
        chk("k_j_ok", 64'(frame_ok), 64'd1);
        chk("k_count", 64'(frame_count), 64'd9);
        chk("k_width", 64'(meas_width), 64'd2);
        send_line(4, 1'b0, 1'b0);
        send_line(4, 1'b0, 1'b0);
        clr_err = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        clr_err = 1'b0;
        chk("l_k_ok", 64'(frame_ok), 64'd0);
        chk("l_k_height", 64'(meas_height), 64'd3);
        chk("l_count", 64'(frame_count), 64'd10);
        chk("l_clr_new_err", 64'(err_count), 64'd1);
        chk("l_clr_flags", 64'({err_line_len, err_frame_len, err_sof_midline}), 64'd0);
        clr_err = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        clr_err = 1'b0;
        chk("clr_err_count", 64'(err_count), 64'd0);
        chk("clr_count_kept", 64'(frame_count), 64'd10);

`ifdef VID_MON_CHECKSUM_EN
        // 4x2 frames, tdata = {A5A5, beat+1}; hand-folded sum is 32'h00065551.
        exp_width = 16'd4;
        exp_height = 16'd2;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 4; i++) begin
                dval = {16'hA5A5, 32'(i + 1)};
                step(1'b1, 1'b1, i == 0, i[0]);
                if (i == 0 && f > 0) begin
                    chk("cks_value", 64'(frame_checksum), 64'h65551);
                    chk("cks_ok", 64'(frame_ok), 64'd1);
                end
            end
        end
`else
        chk("cks_tied_zero", 64'(frame_checksum), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
